// File: rtl/dsp_wresp_channel_if.sv
// Write-response bundle between the slave arbiters, the master port and AW.
// Slave-side fields are packed per slave index.
interface dsp_wresp_channel_if #(
  parameter int SLV_AMT         = 2,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int SLV_ID_W        = $clog2(SLV_AMT)
);
  logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_BID_i;
  logic [TRANS_WR_RESP_W*SLV_AMT-1:0] sa_BRESP_i;
  logic [SLV_AMT-1:0]                 sa_BVALID_i;
  logic [SLV_AMT-1:0]                 sa_BREADY_o;
  logic [TRANS_MST_ID_W-1:0]          m_BID_o;
  logic [TRANS_WR_RESP_W-1:0]         m_BRESP_o;
  logic                               m_BVALID_o;
  logic                               m_BREADY_i;
  logic [SLV_ID_W-1:0]                AW_slv_id_i;
  logic                               AW_shift_en_i;
  logic                               AW_stall_o;

  modport slave (
    input  sa_BID_i, sa_BRESP_i, sa_BVALID_i,
    input  m_BREADY_i, AW_slv_id_i, AW_shift_en_i,
    output sa_BREADY_o, m_BID_o, m_BRESP_o,
    output m_BVALID_o, AW_stall_o
  );

  modport master (
    output sa_BID_i, sa_BRESP_i, sa_BVALID_i,
    output m_BREADY_i, AW_slv_id_i, AW_shift_en_i,
    input  sa_BREADY_o, m_BID_o, m_BRESP_o,
    input  m_BVALID_o, AW_stall_o
  );
endinterface

// File: rtl/dsp_wresp_channel.sv
// In-order write-response return path for one master.
// B responses are taken only from the slave at the head of the AW order.
module dsp_wresp_channel #(
  parameter int SLV_AMT         = 2,
  parameter int OUTSTANDING_AMT = 8,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2
) (
  input logic ACLK_i,
  input logic ARESETn_i,
  dsp_wresp_channel_if.slave bus
);
  localparam int PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(OUTSTANDING_AMT);

  logic [SLV_ID_W-1:0] fifo_q [OUTSTANDING_AMT];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [SLV_ID_W-1:0] head;
  logic full;
  logic empty;
  logic load_ok;
  logic push;
  logic pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign head    = fifo_q[rd_ptr];
  assign load_ok = !bus.m_BVALID_o || bus.m_BREADY_i;
  assign push    = bus.AW_shift_en_i && !full;
  assign pop     = |(bus.sa_BVALID_i & bus.sa_BREADY_o);

  assign bus.AW_stall_o = full;

  // Ready is a pure function of order state, never of BVALID.
  always_comb begin
    bus.sa_BREADY_o = '0;
    if (!empty && load_ok)
      bus.sa_BREADY_o[head] = 1'b1;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (push)
      fifo_q[wr_ptr] <= bus.AW_slv_id_i;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      bus.m_BVALID_o <= 1'b0;
      bus.m_BID_o    <= '0;
      bus.m_BRESP_o  <= '0;
    end else if (pop) begin
      bus.m_BVALID_o <= 1'b1;
      bus.m_BID_o    <= bus.sa_BID_i[
        TRANS_MST_ID_W*head +: TRANS_MST_ID_W];
      bus.m_BRESP_o  <= bus.sa_BRESP_i[
        TRANS_WR_RESP_W*head +: TRANS_WR_RESP_W];
    end else if (bus.m_BREADY_i) begin
      bus.m_BVALID_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dsp_wresp_channel.sv
// Bench for dsp_wresp_channel: queue-based reference model,
// directed ordering/backpressure/full/reset cases, then random traffic.
module tb_dsp_wresp_channel;
  localparam int SLV = 2;
  localparam int OA  = 8;
  localparam int IDW = 5;
  localparam int RW  = 2;

  logic clk;
  logic rst_n;

  dsp_wresp_channel_if #(
    .SLV_AMT(SLV), .TRANS_MST_ID_W(IDW),
    .TRANS_WR_RESP_W(RW)
  ) bus ();

  dsp_wresp_channel #(
    .SLV_AMT(SLV), .OUTSTANDING_AMT(OA),
    .TRANS_MST_ID_W(IDW), .TRANS_WR_RESP_W(RW)
  ) dut (
    .ACLK_i(clk),
    .ARESETn_i(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int q[$];
  bit mv;
  int mbid;
  int mbresp;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mv = 0;
    mbid = 0;
    mbresp = 0;
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic cycle();
    int er;
    int h;
    bit pop;
    bit push;
    bit mhs;
    #1;
    er = 0;
    if (q.size() > 0 && (!mv || bus.m_BREADY_i))
      er = 1 << q[0];
    chk("sa_bready", 32'(bus.sa_BREADY_o), er);
    chk("aw_stall", 32'(bus.AW_stall_o), 32'(q.size() == OA));
    chk("m_bvalid", 32'(bus.m_BVALID_o), 32'(mv));
    chk("m_bid", 32'(bus.m_BID_o), mbid);
    chk("m_bresp", 32'(bus.m_BRESP_o), mbresp);
    pop = 0;
    if (er != 0)
      pop = bus.sa_BVALID_i[q[0]];
    mhs = mv && bus.m_BREADY_i;
    push = bus.AW_shift_en_i && q.size() < OA;
    if (pop) begin
      h = q.pop_front();
      mv = 1;
      mbid = int'(bus.sa_BID_i >> (IDW*h)) & 31;
      mbresp = int'(bus.sa_BRESP_i >> (RW*h)) & 3;
    end else if (mhs) begin
      mv = 0;
    end
    if (push)
      q.push_back(int'(bus.AW_slv_id_i));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.AW_shift_en_i = 0;
    bus.sa_BVALID_i = '0;
  endtask

  task automatic push_id(int id);
    bus.AW_shift_en_i = 1;
    bus.AW_slv_id_i = 1'(id);
    cycle();
    bus.AW_shift_en_i = 0;
  endtask

  task automatic drain();
    int k;
    bus.AW_shift_en_i = 0;
    bus.sa_BVALID_i = '1;
    bus.m_BREADY_i = 1;
    k = 0;
    while ((q.size() > 0 || mv) && k < 40) begin
      cycle();
      k++;
    end
    bus.sa_BVALID_i = '0;
    chk("drain_bvalid", 32'(bus.m_BVALID_o), 0);
    chk("drain_stall", 32'(bus.AW_stall_o), 0);
  endtask

  initial begin
    logic [IDW-1:0] held_bid;
    logic [RW-1:0] held_resp;
    rst_n = 0;
    bus.sa_BID_i = '0;
    bus.sa_BRESP_i = '0;
    bus.sa_BVALID_i = '0;
    bus.m_BREADY_i = 0;
    bus.AW_slv_id_i = '0;
    bus.AW_shift_en_i = 0;
    model_reset();
    #3;
    chk("rst_bvalid", 32'(bus.m_BVALID_o), 0);
    chk("rst_bready", 32'(bus.sa_BREADY_o), 0);
    chk("rst_stall", 32'(bus.AW_stall_o), 0);
    #9 rst_n = 1;

    // In-order: slave 1 then slave 0, both respond at once
    push_id(1);
    push_id(0);
    bus.sa_BID_i = {5'd7, 5'd3};
    bus.sa_BRESP_i = {2'd2, 2'd1};
    bus.sa_BVALID_i = 2'b11;
    bus.m_BREADY_i = 1;
    #1 chk("ino_rdy0", 32'(bus.sa_BREADY_o[0]), 0);
    cycle();
    chk("ino_bid1", 32'(bus.m_BID_o), 7);
    cycle();
    chk("ino_bid2", 32'(bus.m_BID_o), 3);
    drain();

    // Back-pressure: master stalls 5 cycles
    push_id(0);
    push_id(0);
    bus.m_BREADY_i = 0;
    bus.sa_BID_i = {5'd0, 5'd9};
    bus.sa_BRESP_i = {2'd0, 2'd2};
    bus.sa_BVALID_i = 2'b01;
    cycle();
    bus.sa_BID_i = {5'd0, 5'd12};
    bus.sa_BRESP_i = {2'd0, 2'd3};
    held_bid = bus.m_BID_o;
    held_resp = bus.m_BRESP_o;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_bvalid", 32'(bus.m_BVALID_o), 1);
      chk("bp_bid", 32'(bus.m_BID_o), 32'(held_bid));
      chk("bp_bresp", 32'(bus.m_BRESP_o), 32'(held_resp));
      chk("bp_bready", 32'(bus.sa_BREADY_o), 0);
    end
    bus.m_BREADY_i = 1;
    cycle();
    chk("bp_next_bid", 32'(bus.m_BID_o), 12);
    chk("bp_next_valid", 32'(bus.m_BVALID_o), 1);
    drain();

    // Full: 8 pushes, 9th dropped, one pop releases stall
    for (int i = 0; i < OA; i++)
      push_id(int'($urandom_range(0, 1)));
    chk("full_stall", 32'(bus.AW_stall_o), 1);
    push_id(1);
    chk("full_hold", 32'(bus.AW_stall_o), 1);
    bus.sa_BVALID_i = 2'(1 << q[0]);
    cycle();
    bus.sa_BVALID_i = '0;
    chk("full_release", 32'(bus.AW_stall_o), 0);
    drain();

    // Throughput: 8 back-to-back responses from slave 0
    for (int i = 0; i < OA; i++)
      push_id(0);
    bus.m_BREADY_i = 1;
    bus.sa_BVALID_i = 2'b01;
    for (int i = 0; i < OA; i++) begin
      bus.sa_BID_i = {5'd0, 5'(i)};
      bus.sa_BRESP_i = {2'd0, 2'(i % 4)};
      cycle();
      chk("tp_valid", 32'(bus.m_BVALID_o), 1);
      chk("tp_bresp", 32'(bus.m_BRESP_o), i % 4);
      chk("tp_bid", 32'(bus.m_BID_o), i);
    end
    drain();

    // Spurious response with empty order FIFO
    bus.sa_BVALID_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("spur_bready", 32'(bus.sa_BREADY_o), 0);
      chk("spur_bvalid", 32'(bus.m_BVALID_o), 0);
    end
    idle();

    // Reset mid-operation: 3 pending plus a held response
    bus.m_BREADY_i = 0;
    for (int i = 0; i < 4; i++)
      push_id(0);
    bus.sa_BID_i = {5'd0, 5'd21};
    bus.sa_BRESP_i = {2'd0, 2'd3};
    bus.sa_BVALID_i = 2'b01;
    cycle();
    bus.sa_BVALID_i = '0;
    chk("pre_rst_valid", 32'(bus.m_BVALID_o), 1);
    rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_valid", 32'(bus.m_BVALID_o), 0);
    chk("mid_rst_bid", 32'(bus.m_BID_o), 0);
    chk("mid_rst_bresp", 32'(bus.m_BRESP_o), 0);
    chk("mid_rst_bready", 32'(bus.sa_BREADY_o), 0);
    chk("mid_rst_stall", 32'(bus.AW_stall_o), 0);
    chk("mid_rst_count", 32'(dut.count), 0);
    #1 rst_n = 1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.AW_shift_en_i = 1'($urandom_range(0, 2) == 0);
      bus.AW_slv_id_i = 1'($urandom);
      bus.sa_BVALID_i = 2'($urandom);
      bus.sa_BID_i = 10'($urandom);
      bus.sa_BRESP_i = 4'($urandom);
      bus.m_BREADY_i = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
